// File: rtl/axilite_write_data_if.sv
// AXI4-Lite write-channel bundle (AW, W, B) shared by the register-bank writer and its master.
interface axilite_write_data_if #(
    parameter int ADDR_SIZE  = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_SIZE-1:0]    awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axilite_write_data.sv
// AXI4-Lite write responder: collects AW and W in any order, applies a strobed word write
// to a flat register vector, then returns a B response.
module axilite_write_data #(
    parameter int DATA_SIZE   = 128,
    parameter int ADDR_SIZE   = 32,
    parameter int DATA_WIDTH  = 32,
    parameter logic [1:0] RESP_OKAY   = 2'd0,
    parameter logic [1:0] RESP_EXOKAY = 2'd1,
    parameter logic [1:0] RESP_SLVERR = 2'd2,
    parameter logic [1:0] RESP_DECERR = 2'd3
) (
    input  logic                 clk,
    input  logic                 rst,
    axilite_write_data_if.slave  bus,
    output logic [DATA_SIZE-1:0] data,
    output logic                 write_pulse
);
    localparam int STRB      = DATA_WIDTH / 8;
    localparam int NUM_WORDS = DATA_SIZE / DATA_WIDTH;
    localparam int LSB       = $clog2(STRB);
    localparam int WIDX      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int MAX_ADDR  = (DATA_SIZE - DATA_WIDTH) / 8;

    typedef enum logic [1:0] {S_COLLECT, S_COMMIT, S_RESP} state_t;

    state_t                r_state;
    logic                  r_awready;
    logic                  r_wready;
    logic                  r_aw_held;
    logic                  r_w_held;
    logic [ADDR_SIZE-1:0]  r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB-1:0]       r_wstrb;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_write_pulse;
    logic [DATA_SIZE-1:0]  r_data;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_addr_err;
    logic [WIDX-1:0]       w_word_idx;
    logic [DATA_SIZE-1:0]  w_data_next;

    assign w_aw_hs    = bus.awvalid && r_awready;
    assign w_w_hs     = bus.wvalid && r_wready;
    // Range test is done on the byte address so a huge addr cannot wrap when scaled to bits.
    assign w_addr_err = (r_addr > ADDR_SIZE'(MAX_ADDR)) || (r_addr[LSB-1:0] != '0);
    assign w_word_idx = r_addr[LSB +: WIDX];

    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_WORDS; gi++) begin : g_word
            for (gj = 0; gj < STRB; gj++) begin : g_lane
                assign w_data_next[gi*DATA_WIDTH + 8*gj +: 8] =
                    (!w_addr_err && (w_word_idx == WIDX'(gi)) && r_wstrb[gj])
                        ? r_wdata[8*gj +: 8]
                        : r_data[gi*DATA_WIDTH + 8*gj +: 8];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_COLLECT;
            r_awready     <= 1'b0;
            r_wready      <= 1'b0;
            r_aw_held     <= 1'b0;
            r_w_held      <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_bvalid      <= 1'b0;
            r_bresp       <= RESP_OKAY;
            r_write_pulse <= 1'b0;
            r_data        <= '0;
        end else begin
            r_write_pulse <= 1'b0;
            case (r_state)
                S_COLLECT: begin
                    if (w_aw_hs) begin
                        r_addr    <= bus.awaddr;
                        r_aw_held <= 1'b1;
                        r_awready <= 1'b0;
                    end else if (!r_aw_held) begin
                        r_awready <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wdata  <= bus.wdata;
                        r_wstrb  <= bus.wstrb;
                        r_w_held <= 1'b1;
                        r_wready <= 1'b0;
                    end else if (!r_w_held) begin
                        r_wready <= 1'b1;
                    end
                    if (r_aw_held && r_w_held) begin
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    r_data   <= w_data_next;
                    r_bvalid <= 1'b1;
                    if (w_addr_err) begin
                        r_bresp <= RESP_SLVERR;
                    end else begin
                        r_bresp       <= RESP_OKAY;
                        r_write_pulse <= 1'b1;
                    end
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (bus.bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_state   <= S_COLLECT;
                    end
                end
                default: r_state <= S_COLLECT;
            endcase
        end
    end

    assign bus.awready = r_awready;
    assign bus.wready  = r_wready;
    assign bus.bvalid  = r_bvalid;
    assign bus.bresp   = r_bresp;
    assign data        = r_data;
    assign write_pulse = r_write_pulse;
endmodule

// File: tb/tb_axilite_write_data.sv
// Directed bench for axilite_write_data: table of write transactions plus hand-written
// backpressure and mid-transaction reset sequences.
module tb_axilite_write_data;
    logic         clk;
    logic         rst;
    logic [127:0] data;
    logic         write_pulse;
    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;

    axilite_write_data_if #(.ADDR_SIZE(32), .DATA_WIDTH(32)) bus ();

    axilite_write_data #(.DATA_SIZE(128), .ADDR_SIZE(32), .DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .data        (data),
        .write_pulse (write_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic [3:0]   strb;
        int           daw;
        int           dw;
        logic [1:0]   resp;
        logic [127:0] data;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_aw(input logic [31:0] a, input int d, output int eid);
        eid = -1;
        repeat (d) @(negedge clk);
        bus.awaddr  = a;
        bus.awvalid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (bus.awready) begin
                eid = cyc + 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        bus.awvalid = 1'b0;
    endtask

    task automatic drive_w(input logic [31:0] wd, input logic [3:0] st, input int d, output int eid);
        eid = -1;
        repeat (d) @(negedge clk);
        bus.wdata  = wd;
        bus.wstrb  = st;
        bus.wvalid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (bus.wready) begin
                eid = cyc + 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        bus.wvalid = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                            input int daw, input int dw, input int hold,
                            input logic [1:0] exp_resp, input logic [127:0] exp_data);
        int  e_aw, e_w, n_edge;
        bit  seen;
        logic [1:0] resp_seen;
        @(negedge clk);
        bus.bready = (hold == 0);
        fork
            drive_aw(a, daw, e_aw);
            drive_w(wd, st, dw, e_w);
        join
        chk("aw_handshake", 128'(e_aw >= 0), 128'(1));
        chk("w_handshake", 128'(e_w >= 0), 128'(1));
        n_edge = (e_aw > e_w) ? e_aw : e_w;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.bvalid) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk("bvalid_seen", 128'(seen), 128'(1));
        resp_seen = bus.bresp;
        chk("commit_latency", 128'(cyc), 128'(n_edge + 2));
        chk("bresp", 128'(bus.bresp), 128'(exp_resp));
        chk("write_pulse", 128'(write_pulse), 128'(exp_resp == 2'd0));
        chk("data", data, exp_data);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("bp_bvalid", 128'(bus.bvalid), 128'(1));
            chk("bp_bresp", 128'(bus.bresp), 128'(resp_seen));
            chk("bp_awready", 128'(bus.awready), 128'(0));
            chk("bp_wready", 128'(bus.wready), 128'(0));
            chk("bp_pulse", 128'(write_pulse), 128'(0));
        end
        bus.bready = 1'b1;
        @(negedge clk);
        chk("b_done_bvalid", 128'(bus.bvalid), 128'(0));
        chk("b_done_awready", 128'(bus.awready), 128'(1));
        chk("b_done_wready", 128'(bus.wready), 128'(1));
        chk("pulse_one_cycle", 128'(write_pulse), 128'(0));
        $display("write addr=%h wdata=%h strb=%h resp=%0d data=%h", a, wd, st, resp_seen, data);
    endtask

    initial begin
        int eid;
        bit stray;
        vecs[0] = '{32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 2'd0, 128'h00000000_00000000_DEADBEEF_00000000};
        vecs[1] = '{32'h0, 32'h12345678, 4'hF, 3, 0, 2'd0, 128'h00000000_00000000_DEADBEEF_12345678};
        vecs[2] = '{32'h8, 32'hFFFFFFFF, 4'hF, 0, 2, 2'd0, 128'h00000000_FFFFFFFF_DEADBEEF_12345678};
        vecs[3] = '{32'h8, 32'h00000000, 4'h5, 1, 1, 2'd0, 128'h00000000_FF00FF00_DEADBEEF_12345678};
        vecs[4] = '{32'h10, 32'hBAD0BAD0, 4'hF, 0, 0, 2'd2, 128'h00000000_FF00FF00_DEADBEEF_12345678};
        vecs[5] = '{32'h2, 32'hBAD1BAD1, 4'hF, 0, 0, 2'd2, 128'h00000000_FF00FF00_DEADBEEF_12345678};
        vecs[6] = '{32'hC, 32'hA5A5A5A5, 4'h0, 0, 0, 2'd0, 128'h00000000_FF00FF00_DEADBEEF_12345678};
        vecs[7] = '{32'hC, 32'hCAFEF00D, 4'h8, 0, 0, 2'd0, 128'hCA000000_FF00FF00_DEADBEEF_12345678};

        rst = 1'b0;
        bus.awaddr = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b1;
        #1;
        chk("rst_awready", 128'(bus.awready), 128'(0));
        chk("rst_wready", 128'(bus.wready), 128'(0));
        chk("rst_bvalid", 128'(bus.bvalid), 128'(0));
        chk("rst_bresp", 128'(bus.bresp), 128'(0));
        chk("rst_pulse", 128'(write_pulse), 128'(0));
        chk("rst_data", data, 128'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("release_awready", 128'(bus.awready), 128'(1));
        chk("release_wready", 128'(bus.wready), 128'(1));

        for (int i = 0; i < 8; i++) begin
            do_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].daw, vecs[i].dw, 0,
                     vecs[i].resp, vecs[i].data);
        end

        // Backpressure: bready low for five cycles after bvalid rises.
        do_write(32'h4, 32'h11112222, 4'hF, 0, 0, 5, 2'd0,
                 128'hCA000000_FF00FF00_11112222_12345678);
        // Leave bresp at SLVERR so the reset check below is meaningful.
        do_write(32'h10, 32'h0BADF00D, 4'hF, 0, 0, 0, 2'd2,
                 128'hCA000000_FF00FF00_11112222_12345678);

        // Reset with only AW held, then W alone must not write.
        drive_aw(32'h0, 0, eid);
        chk("rst_seq_aw_hs", 128'(eid >= 0), 128'(1));
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_awready", 128'(bus.awready), 128'(0));
        chk("midrst_wready", 128'(bus.wready), 128'(0));
        chk("midrst_bvalid", 128'(bus.bvalid), 128'(0));
        chk("midrst_bresp", 128'(bus.bresp), 128'(0));
        chk("midrst_pulse", 128'(write_pulse), 128'(0));
        chk("midrst_data", data, 128'h0);
        @(negedge clk);
        rst = 1'b1;
        drive_w(32'hFFFFFFFF, 4'hF, 0, eid);
        chk("rst_seq_w_hs", 128'(eid >= 0), 128'(1));
        stray = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.bvalid || write_pulse) stray = 1;
            @(negedge clk);
        end
        chk("w_alone_no_resp", 128'(stray), 128'(0));
        chk("w_alone_data", data, 128'h0);
        chk("w_alone_awready", 128'(bus.awready), 128'(1));
        $display("reset mid-transaction: data=%h bvalid=%0d", data, bus.bvalid);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/axilite_write_data.md
# axilite_write_data

AXI4-Lite write-channel responder for the coprocessor's register bank. It accepts an AW beat and a W beat in either order, writes the addressed DATA_WIDTH-bit word of a flat DATA_SIZE-bit register vector under byte strobes, and returns a B response. It is the write-side counterpart of the block that serves reads from the same vector. Its `data` output feeds both that read path and the control logic.

## Interface
- DATA_SIZE, 128: total register-bank width in bits (multiple of DATA_WIDTH).
- ADDR_SIZE, 32: AW address width.
- DATA_WIDTH, 32: AXI-Lite data width; strobe width is DATA_WIDTH/8.
- RESP_OKAY, 0 / RESP_EXOKAY, 1 / RESP_SLVERR, 2 / RESP_DECERR, 3: response encodings.
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-low reset: asserted when 0; release is synchronous to clk.
- awaddr  in  ADDR_SIZE  byte address.
- awvalid  in  1 / awready  out  1  AW handshake.
- wdata  in  DATA_WIDTH / wstrb  in  DATA_WIDTH/8 / wvalid  in  1 / wready  out  1  W channel.
- bresp  out  2 / bvalid  out  1 / bready  in  1  B channel.
- data  out  DATA_SIZE  register bank contents (registered).
- write_pulse  out  1  one-cycle high on each committed OKAY write.

## Operation
- States:
  - COLLECT: accepting AW and/or W.
  - COMMIT: both beats held.
  - RESP: bvalid high.
- COLLECT:
  - awready = 1 until an AW handshake (awvalid && awready) latches awaddr; awready then drops to 0 at that edge.
  - W is handled identically: wready drops to 0 and wdata and wstrb are latched.
  - AW and W may arrive in either order or on the same edge.
  - When both are held, go to COMMIT.
- COMMIT (exactly one cycle):
  - Address error: latched addr*8 > DATA_SIZE - DATA_WIDTH, or addr not a multiple of DATA_WIDTH/8.
  - On error, bresp <= RESP_SLVERR and `data` is unchanged.
  - Otherwise, for each byte lane i with wstrb[i]=1: data[addr*8 + 8i +: 8] <= wdata[8i +: 8]. Lanes with strobe 0 keep their value. bresp <= RESP_OKAY and write_pulse <= 1.
  - bvalid <= 1; go to RESP.
- RESP:
  - bvalid and bresp are held stable until bvalid && bready.
  - At that edge: bvalid <= 0, awready <= 1, wready <= 1; go to COLLECT.
- bresp retains its last value while bvalid = 0. RESP_EXOKAY and RESP_DECERR are never produced.
- awready and wready are both 0 in COMMIT and RESP, so beats presented early simply wait.
- All-zero wstrb to a valid address: OKAY response, write_pulse = 1, data unchanged.

## Timing
- Reset (rst = 0), asynchronous:
  - awready = 0, wready = 0, bvalid = 0, bresp = RESP_OKAY, write_pulse = 0, data = 0.
  - State = COLLECT with nothing held.
- First edge after release: awready = 1, wready = 1.
- Last handshake (AW or W) at edge N:
  - edge N+1: COMMIT.
  - edge N+2: `data` updated, bvalid = 1, write_pulse = 1 for one cycle.
- bready already high when bvalid rises: B completes at edge N+3; awready and wready are 1 from N+3. Peak rate is one write per 4 cycles.
- Reset asserted mid-transaction: held beats are discarded, outputs return to reset values immediately, and no partial write occurs.

## Test plan
- Basic write:
  - Stimulus: AW addr 0x4 and W 0xDEADBEEF, strb 0xF, on the same edge; bready = 1.
  - Response: data[63:32] = 0xDEADBEEF two edges later; bresp = 0; write_pulse pulses once; other words stay 0.
- W-before-AW:
  - Stimulus: W 0x12345678 to addr 0x0 three cycles before AW.
  - Response: wready drops after its handshake; commit follows the AW edge by two edges; data[31:0] = 0x12345678.
- Partial strobe:
  - Stimulus: word 0x8 preloaded to 0xFFFFFFFF, then write 0x00000000 with strb 0x5.
  - Response: data[95:64] = 0xFF00FF00.
- Error paths:
  - Stimulus: write addr 0x10 (out of range for a 128-bit bank); then write addr 0x2 (misaligned).
  - Response: each gives bresp = 2 with bvalid = 1; data unchanged; write_pulse stays 0.
- Backpressure:
  - Stimulus: bready held low 5 cycles.
  - Response: bvalid and bresp stay stable; awready and wready stay 0; next AW is accepted only after the B handshake.
- Reset mid-operation:
  - Stimulus: rst = 0 after AW is held but before W arrives.
  - Response: all outputs return to reset values asynchronously; a subsequent W alone triggers no write.
